// File: rtl/store_data_buffer_pkg.sv
// store_data_buffer_pkg: shared store-path types and SqN age helper.
package store_data_buffer_pkg;
  localparam int SQN_W = 7;
  typedef logic [SQN_W-1:0] SqN_t;
  typedef struct packed {
    logic valid;
    SqN_t storeSqN;
    logic [31:0] data;
  } StDataUOp;
  typedef struct packed {
    logic taken;
    logic flush;
    SqN_t storeSqN;
  } BranchProv;
  typedef struct packed {
    logic valid;
    SqN_t sqN;
    logic [31:0] data;
  } StDataBufEntry_t;
  function automatic logic SqNYounger(SqN_t a, SqN_t b);
    return $signed(SqN_t'(a - b)) > 0;
  endfunction
endpackage

// File: rtl/store_data_buffer.sv
// store_data_buffer: parks store data by SqN, applies squashes, drains committed data in SqN order.
module store_data_buffer
  import store_data_buffer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NUM_ENTRIES = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  BranchProv IN_branch,
  input  StDataUOp  IN_uop [WIDTH],
  input  SqN_t      IN_comSqN,
  output logic      OUT_full,
  output StDataUOp  OUT_stData,
  input  logic      IN_stReady
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam SqN_t WINDOW = SqN_t'(NUM_ENTRIES);
  StDataBufEntry_t slots [NUM_ENTRIES];
  StDataBufEntry_t slots_nxt [NUM_ENTRIES];
  StDataBufEntry_t head;
  SqN_t base_sqn;
  logic out_valid;
  SqN_t out_sqn;
  logic [31:0] out_data;
  logic full_q;
  logic full_nxt;
  logic load;
  function automatic logic killed(SqN_t s);
    return IN_branch.taken && SqNYounger(s, IN_branch.flush ? IN_comSqN : IN_branch.storeSqN);
  endfunction
  function automatic logic in_window(SqN_t s);
    return SqN_t'(s - base_sqn) < WINDOW;
  endfunction
  function automatic logic [IDX_W-1:0] idx(SqN_t s);
    return s[IDX_W-1:0];
  endfunction
  assign head = slots[idx(base_sqn)];
  // Committed data is never squashed, so draining needs no branch qualification.
  assign load = (!out_valid || IN_stReady) && head.valid && head.sqN == base_sqn &&
                !SqNYounger(base_sqn, IN_comSqN);
  always_comb begin
    slots_nxt = slots;
    for (int k = 0; k < NUM_ENTRIES; k++)
      if (killed(slots[k].sqN)) slots_nxt[k].valid = 1'b0;
    if (load) slots_nxt[idx(base_sqn)].valid = 1'b0;
    // Later ports overwrite earlier ones on a (disallowed) slot collision.
    for (int i = 0; i < WIDTH; i++)
      if (IN_uop[i].valid && in_window(IN_uop[i].storeSqN) && !killed(IN_uop[i].storeSqN))
        slots_nxt[idx(IN_uop[i].storeSqN)] = '{valid: 1'b1, sqN: IN_uop[i].storeSqN, data: IN_uop[i].data};
    full_nxt = 1'b1;
    for (int k = 0; k < NUM_ENTRIES; k++)
      full_nxt = full_nxt && slots_nxt[k].valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '{default: '0};
      base_sqn <= '0;
      out_valid <= 1'b0;
      out_sqn <= '0;
      out_data <= '0;
      full_q <= 1'b0;
    end else begin
      slots <= slots_nxt;
      full_q <= full_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_sqn <= head.sqN;
        out_data <= head.data;
        base_sqn <= base_sqn + SqN_t'(1);
      end else if (IN_stReady) begin
        out_valid <= 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (IN_uop[i].valid && !killed(IN_uop[i].storeSqN)) begin
          assert (in_window(IN_uop[i].storeSqN));
          assert (!in_window(IN_uop[i].storeSqN) || !slots[idx(IN_uop[i].storeSqN)].valid);
        end
        for (int j = i + 1; j < WIDTH; j++)
          assert (!(IN_uop[i].valid && IN_uop[j].valid && idx(IN_uop[i].storeSqN) == idx(IN_uop[j].storeSqN)));
      end
    end
  end
  assign OUT_full = full_q;
  assign OUT_stData = '{valid: out_valid, storeSqN: out_sqn, data: out_data};
endmodule

// File: tb/tb_store_data_buffer.sv
// tb_store_data_buffer: directed table, wrap/stall/reset sequences and a randomized run against a SqN-keyed model.
module tb_store_data_buffer;
  import store_data_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  BranchProv br;
  StDataUOp uop [2];
  SqN_t com;
  logic rdy;
  logic full;
  StDataUOp out;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    bit w0v; SqN_t w0s; logic [31:0] w0d;
    bit w1v; SqN_t w1s; logic [31:0] w1d;
    SqN_t c; bit r; bit bt; bit bf; SqN_t bs;
    bit ev; SqN_t es; logic [31:0] ed; bit ef;
  } vec_t;
  vec_t tbl [30];
  bit pv [128];
  logic [31:0] pd [128];
  int mb;
  bit mov;
  SqN_t mosq;
  logic [31:0] mod;
  bit mfull;

  always #5 clk = ~clk;

  store_data_buffer #(.WIDTH(2), .NUM_ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .IN_branch(br), .IN_uop(uop), .IN_comSqN(com),
    .OUT_full(full), .OUT_stData(out), .IN_stReady(rdy)
  );

  function automatic vec_t v(bit w0v, SqN_t w0s, logic [31:0] w0d, bit w1v, SqN_t w1s, logic [31:0] w1d,
                             SqN_t c, bit r, bit bt, bit bf, SqN_t bs, bit ev, SqN_t es, logic [31:0] ed, bit ef);
    return '{w0v, w0s, w0d, w1v, w1s, w1d, c, r, bt, bf, bs, ev, es, ed, ef};
  endfunction

  function automatic bit yng(SqN_t a, SqN_t b);
    SqN_t d;
    d = a - b;
    return d != 0 && d[6] == 1'b0;
  endfunction

  function automatic bit mkill(SqN_t s, bit bt, bit bf, SqN_t bs, SqN_t c);
    return bt && (bf ? yng(s, c) : yng(s, bs));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit w0v, SqN_t w0s, logic [31:0] w0d, bit w1v, SqN_t w1s, logic [31:0] w1d,
                       SqN_t c, bit r, bit bt, bit bf, SqN_t bs);
    uop[0] = '{valid: w0v, storeSqN: w0s, data: w0d};
    uop[1] = '{valid: w1v, storeSqN: w1s, data: w1d};
    com = c;
    rdy = r;
    br = '{taken: bt, flush: bf, storeSqN: bs};
  endtask

  task automatic chk(string name, logic [39:0] got, logic [39:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_out(string tag, bit ev, SqN_t es, logic [31:0] ed, bit ef);
    chk({tag, ".valid"}, 40'(out.valid), 40'(ev));
    if (ev) begin
      chk({tag, ".sqn"}, 40'(out.storeSqN), 40'(es));
      chk({tag, ".data"}, 40'(out.data), 40'(ed));
    end
    chk({tag, ".full"}, 40'(full), 40'(ef));
  endtask

  task automatic idle(SqN_t c, bit r);
    drive(0, 0, 0, 0, 0, 0, c, r, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = v(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[2]  = v(0, 0, 0, 1, 2, 32'h22, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = v(1, 1, 32'h11, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 1, 32'h11, 0);
    tbl[6]  = v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 2, 32'h22, 0);
    tbl[7]  = v(1, 3, 32'h33, 1, 4, 32'h44, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = v(1, 5, 32'h55, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = v(1, 5, 32'h5A, 0, 0, 0, 2, 1, 1, 0, 3, 0, 0, 0, 0);
    tbl[10] = v(0, 0, 0, 1, 4, 32'h4B, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 3, 32'h33, 0);
    tbl[12] = v(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 4, 32'h4B, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = v(1, 5, 32'h55, 1, 6, 32'h66, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = v(1, 7, 32'h77, 0, 0, 0, 6, 0, 0, 0, 0, 1, 5, 32'h55, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 5, 32'h55, 0);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 5, 32'h55, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 5, 32'h55, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 6, 32'h66, 0);
    tbl[20] = v(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 7, 32'h77, 0);
    tbl[21] = v(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = v(1, 8, 32'h1008, 1, 9, 32'h1009, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[23] = v(1, 10, 32'h100A, 1, 11, 32'h100B, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = v(1, 12, 32'h100C, 1, 13, 32'h100D, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = v(1, 14, 32'h100E, 1, 15, 32'h100F, 7, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1, 8, 32'h1008, 0);
    tbl[27] = v(1, 16, 32'h1010, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[28] = v(0, 0, 0, 0, 0, 0, 9, 1, 1, 1, 0, 1, 9, 32'h1009, 0);
    tbl[29] = v(0, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0, 0);

    idle(0, 1);
    repeat (2) tick();
    check_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_out("post_reset", 0, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      drive(tbl[k].w0v, tbl[k].w0s, tbl[k].w0d, tbl[k].w1v, tbl[k].w1s, tbl[k].w1d,
            tbl[k].c, tbl[k].r, tbl[k].bt, tbl[k].bf, tbl[k].bs);
      tick();
      check_out($sformatf("row%0d", k), tbl[k].ev, tbl[k].es, tbl[k].ed, tbl[k].ef);
    end

    // stream SqN 10..125 so the base reaches 126, then cross the SqN wrap
    for (int s = 10; s < 126; s++) begin
      drive(1, SqN_t'(s), 32'h2000 + s, 0, 0, 0, SqN_t'(s), 1, 0, 0, 0);
      tick();
      check_out($sformatf("stream%0d", s), s != 10, SqN_t'(s - 1), 32'h2000 + s - 1, 0);
    end
    idle(125, 1);
    tick();
    check_out("stream_last", 1, 125, 32'h2000 + 125, 0);
    drive(1, 126, 32'h3126, 1, 127, 32'h3127, 1, 1, 0, 0, 0);
    tick();
    check_out("wrapA", 0, 0, 0, 0);
    drive(1, 0, 32'h3000, 1, 1, 32'h3001, 1, 1, 0, 0, 0);
    tick();
    check_out("wrapB", 1, 126, 32'h3126, 0);
    idle(1, 1);
    tick();
    check_out("wrapC", 1, 127, 32'h3127, 0);
    tick();
    check_out("wrapD", 1, 0, 32'h3000, 0);
    tick();
    check_out("wrapE", 1, 1, 32'h3001, 0);
    tick();
    check_out("wrapF", 0, 0, 0, 0);

    // asynchronous reset with parked data and a stalled output
    drive(1, 2, 32'h4002, 1, 3, 32'h4003, 4, 0, 0, 0, 0);
    tick();
    check_out("rstG", 0, 0, 0, 0);
    drive(1, 4, 32'h4004, 1, 5, 32'h4005, 4, 0, 0, 0, 0);
    tick();
    check_out("rstH", 1, 2, 32'h4002, 0);
    drive(1, 6, 32'h4006, 0, 0, 0, 4, 0, 0, 0, 0);
    tick();
    check_out("rstI", 1, 2, 32'h4002, 0);
    idle(4, 0);
    #2 rst = 1'b1;
    #1;
    check_out("rst_async", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 32'h5000, 1, 1, 32'h5001, 127, 1, 0, 0, 0);
    tick();
    check_out("after_rst0", 0, 0, 0, 0);
    drive(1, 2, 32'h5002, 1, 7, 32'h5007, 127, 1, 0, 0, 0);
    tick();
    check_out("after_rst1", 0, 0, 0, 0);
    idle(0, 1);
    tick();
    check_out("after_rst2", 1, 0, 32'h5000, 0);

    // randomized run against a model keyed by full SqN
    idle(0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 128; s++) pv[s] = 0;
    mb = 0;
    mov = 0;
    mfull = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, bt, bf, elig, ld;
      SqN_t c, bs;
      bit wv [2];
      SqN_t ws [2];
      logic [31:0] wd [2];
      int cnt;
      r = ($urandom % 4) != 0;
      c = SqN_t'(mb + $urandom_range(0, 9) - 2);
      bt = ($urandom % 12) == 0;
      bf = ($urandom % 2) == 1;
      bs = SqN_t'(c + $urandom_range(0, 4));
      for (int p = 0; p < 2; p++) begin
        ws[p] = SqN_t'(mb + $urandom_range(0, 7));
        wd[p] = $urandom;
        wv[p] = ($urandom % 2) == 1 && !pv[ws[p]] && !(p == 1 && wv[0] && ws[0] == ws[1]);
      end
      drive(wv[0], ws[0], wd[0], wv[1], ws[1], wd[1], c, r, bt, bf, bs);
      elig = pv[mb] && !yng(SqN_t'(mb), c);
      ld = (!mov || r) && elig;
      for (int s = 0; s < 128; s++)
        if (pv[s] && mkill(SqN_t'(s), bt, bf, bs, c)) pv[s] = 0;
      if (ld) begin
        mov = 1;
        mosq = SqN_t'(mb);
        mod = pd[mb];
        pv[mb] = 0;
        mb = (mb + 1) % 128;
      end else if (r) begin
        mov = 0;
      end
      for (int p = 0; p < 2; p++)
        if (wv[p] && !mkill(ws[p], bt, bf, bs, c)) begin
          pv[ws[p]] = 1;
          pd[ws[p]] = wd[p];
        end
      cnt = 0;
      for (int s = 0; s < 128; s++) cnt += int'(pv[s]);
      mfull = cnt == 8;
      tick();
      check_out($sformatf("rand%0d", n), mov, mosq, mod, mfull);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
